// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, ALU/memory op codes, forwarding-bus layout
// and the ID/EX payload type used by the decode stage.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [3:0] {
    ALU_NOP = 4'h0,
    ALU_ADD = 4'h1,
    ALU_SUB = 4'h2,
    ALU_AND = 4'h3,
    ALU_OR  = 4'h4,
    ALU_XOR = 4'h5,
    ALU_SLT = 4'h6,
    ALU_SLL = 4'h7,
    ALU_SRL = 4'h8
  } alu_op_e;

  typedef enum logic [1:0] {
    MEMOP_NONE = 2'b00,
    MEMOP_LW   = 2'b01,
    MEMOP_SW   = 2'b10
  } mem_op_e;

  // EX bus: {we, is_load, waddr[4:0], wdata[31:0]}; MEM bus: {we, waddr[4:0], wdata[31:0]}
  localparam int EX_FWD_WE    = 38;
  localparam int EX_FWD_LOAD  = 37;
  localparam int EX_FWD_ADDR  = 32;
  localparam int MEM_FWD_WE   = 37;
  localparam int MEM_FWD_ADDR = 32;

  typedef struct packed {
    logic        valid;
    alu_op_e     aluop;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        we;
    logic [4:0]  waddr;
    mem_op_e     memop;
    logic [31:0] store_data;
    logic        illegal;
  } id_ex_t;

  function automatic alu_op_e funct_to_aluop(input logic [5:0] funct);
    case (funct)
      FN_ADDU: return ALU_ADD;
      FN_SUBU: return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_XOR:  return ALU_XOR;
      FN_SLT:  return ALU_SLT;
      FN_SLL:  return ALU_SLL;
      FN_SRL:  return ALU_SRL;
      default: return ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/id_operand_fwd.sv
// Selects one source operand: $0, then EX result (non-load), then MEM result,
// then the register file.
module id_operand_fwd (
  input  logic [4:0]  addr,
  input  logic [31:0] rf_data,
  input  logic [38:0] ex_fwd,
  input  logic [37:0] mem_fwd,
  output logic [31:0] value
);
  import mips_pkg::*;

  always_comb begin
    if (addr == 5'd0)
      value = 32'd0;
    else if (ex_fwd[EX_FWD_WE] && !ex_fwd[EX_FWD_LOAD] && (ex_fwd[EX_FWD_ADDR +: 5] == addr))
      value = ex_fwd[31:0];
    else if (mem_fwd[MEM_FWD_WE] && (mem_fwd[MEM_FWD_ADDR +: 5] == addr))
      value = mem_fwd[31:0];
    else
      value = rf_data;
  end

endmodule

// File: rtl/id_fwd_stage.sv
// Decode stage: operand forwarding, load-use detection, branch resolution in ID
// and the ID/EX pipeline register.
module id_fwd_stage #(
  parameter int STALL_W    = 6,
  parameter int STAGE      = 2,
  parameter bit DELAY_SLOT = 1'b1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               id_valid_i,
  input  logic [31:0]        id_inst_i,
  input  logic [31:0]        id_pc_i,
  output logic [9:0]         rf_raddr_o,
  input  logic [63:0]        rf_rdata_i,
  input  logic [38:0]        ex_fwd_i,
  input  logic [37:0]        mem_fwd_i,
  output logic               stall_req_o,
  output logic               br_taken_o,
  output logic [31:0]        br_target_o,
  output logic               if_flush_o,
  output logic               ex_valid_o,
  output logic [3:0]         ex_aluop_o,
  output logic [31:0]        ex_op1_o,
  output logic [31:0]        ex_op2_o,
  output logic               ex_we_o,
  output logic [4:0]         ex_waddr_o,
  output logic [1:0]         ex_memop_o,
  output logic [31:0]        ex_store_data_o,
  output logic               ex_illegal_o
);
  import mips_pkg::*;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext, imm_zext, pc_plus4, pc_plus8, rs_val, rt_val;
  logic [4:0]  ex_waddr;
  logic        uses_rs, uses_rt, is_beq, is_bne, is_jimm, is_jr, br_cond;
  logic        unused_stall;
  id_ex_t      dec, ex_q;

  assign opcode   = id_inst_i[31:26];
  assign rs       = id_inst_i[25:21];
  assign rt       = id_inst_i[20:16];
  assign rd       = id_inst_i[15:11];
  assign funct    = id_inst_i[5:0];
  assign imm_sext = {{16{id_inst_i[15]}}, id_inst_i[15:0]};
  assign imm_zext = {16'd0, id_inst_i[15:0]};
  assign pc_plus4 = id_pc_i + 32'd4;
  assign pc_plus8 = id_pc_i + 32'd8;
  assign ex_waddr = ex_fwd_i[EX_FWD_ADDR +: 5];
  assign unused_stall = ^stall;

  assign rf_raddr_o = {rt, rs};

  id_operand_fwd u_fwd_rs (
    .addr(rs), .rf_data(rf_rdata_i[31:0]), .ex_fwd(ex_fwd_i), .mem_fwd(mem_fwd_i), .value(rs_val)
  );

  id_operand_fwd u_fwd_rt (
    .addr(rt), .rf_data(rf_rdata_i[63:32]), .ex_fwd(ex_fwd_i), .mem_fwd(mem_fwd_i), .value(rt_val)
  );

  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    uses_rs   = 1'b0;
    uses_rt   = 1'b0;
    is_beq    = 1'b0;
    is_bne    = 1'b0;
    is_jimm   = 1'b0;
    is_jr     = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_SLT: begin
            uses_rs = 1'b1; uses_rt = 1'b1;
            dec.op1 = rs_val; dec.op2 = rt_val;
            dec.we  = 1'b1; dec.waddr = rd; dec.aluop = funct_to_aluop(funct);
          end
          FN_SLL, FN_SRL: begin
            uses_rt = 1'b1;
            dec.op1 = {27'd0, id_inst_i[10:6]}; dec.op2 = rt_val;
            dec.we  = 1'b1; dec.waddr = rd; dec.aluop = funct_to_aluop(funct);
          end
          FN_JR: begin
            uses_rs = 1'b1; is_jr = 1'b1;
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
        uses_rs   = 1'b1;
        dec.op1   = rs_val;
        dec.op2   = (opcode == OP_ADDIU || opcode == OP_SLTI) ? imm_sext : imm_zext;
        dec.we    = 1'b1;
        dec.waddr = rt;
        case (opcode)
          OP_ADDIU: dec.aluop = ALU_ADD;
          OP_SLTI:  dec.aluop = ALU_SLT;
          OP_ANDI:  dec.aluop = ALU_AND;
          OP_ORI:   dec.aluop = ALU_OR;
          default:  dec.aluop = ALU_XOR;
        endcase
      end
      OP_LUI: begin
        dec.op2 = {id_inst_i[15:0], 16'd0}; dec.aluop = ALU_OR;
        dec.we  = 1'b1; dec.waddr = rt;
      end
      OP_LW: begin
        uses_rs = 1'b1;
        dec.op1 = rs_val; dec.op2 = imm_sext; dec.aluop = ALU_ADD;
        dec.we  = 1'b1; dec.waddr = rt; dec.memop = MEMOP_LW;
      end
      OP_SW: begin
        uses_rs = 1'b1; uses_rt = 1'b1;
        dec.op1 = rs_val; dec.op2 = imm_sext; dec.aluop = ALU_ADD;
        dec.memop = MEMOP_SW; dec.store_data = rt_val;
      end
      OP_BEQ, OP_BNE: begin
        uses_rs = 1'b1; uses_rt = 1'b1;
        is_beq  = (opcode == OP_BEQ);
        is_bne  = (opcode == OP_BNE);
        dec.op1 = rs_val; dec.op2 = imm_sext;
      end
      OP_J: is_jimm = 1'b1;
      OP_JAL: begin
        is_jimm = 1'b1;
        dec.we  = 1'b1; dec.waddr = 5'd31; dec.aluop = ALU_ADD;
        dec.op1 = DELAY_SLOT ? pc_plus8 : pc_plus4;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // A load still in EX cannot forward yet, so any real reader of its target waits a cycle.
  assign stall_req_o = id_valid_i && ex_fwd_i[EX_FWD_WE] && ex_fwd_i[EX_FWD_LOAD] &&
                       (ex_waddr != 5'd0) &&
                       ((uses_rs && (ex_waddr == rs)) || (uses_rt && (ex_waddr == rt)));

  always_comb begin
    br_cond     = 1'b0;
    br_target_o = pc_plus4 + (imm_sext << 2);
    if (is_beq) begin
      br_cond = (rs_val == rt_val);
    end else if (is_bne) begin
      br_cond = (rs_val != rt_val);
    end else if (is_jimm) begin
      br_cond     = 1'b1;
      br_target_o = {pc_plus4[31:28], id_inst_i[25:0], 2'b00};
    end else if (is_jr) begin
      br_cond     = 1'b1;
      br_target_o = rs_val;
    end
  end

  assign br_taken_o = id_valid_i && !stall_req_o && !stall[STAGE] && br_cond;
  assign if_flush_o = DELAY_SLOT ? 1'b0 : br_taken_o;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      ex_q <= '0;
    else if (flush)
      ex_q <= '0;
    else if (stall[STAGE] && stall[STAGE+1])
      ex_q <= ex_q;
    else if (stall[STAGE] || stall_req_o || !id_valid_i)
      ex_q <= '0;
    else
      ex_q <= dec;
  end

  assign ex_valid_o      = ex_q.valid;
  assign ex_aluop_o      = ex_q.aluop;
  assign ex_op1_o        = ex_q.op1;
  assign ex_op2_o        = ex_q.op2;
  assign ex_we_o         = ex_q.we;
  assign ex_waddr_o      = ex_q.waddr;
  assign ex_memop_o      = ex_q.memop;
  assign ex_store_data_o = ex_q.store_data;
  assign ex_illegal_o    = ex_q.illegal;

endmodule

// File: doc/id_fwd_stage.md
# id_fwd_stage

Parametrised instruction-decode stage with an ID/EX pipeline register, operand forwarding, load-use hazard detection and in-ID branch resolution. It sits between the IF/ID register and EX. It drives the register-file read addresses and returns resolved jump/branch targets to IF. A build-time mode selects whether a taken branch keeps its MIPS delay slot or squashes it.

## Interface
- `STALL_W`, 6, width of the pipeline-controller stall bus.
- `STAGE`, 2, index of this stage in `stall`; bit `STAGE+1` is EX.
- `DELAY_SLOT`, 1, 1 = delay slot executes; 0 = slot instruction squashed via `if_flush_o`.
- `clk`  in  1  clock; all state on rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `stall`  in  STALL_W  per-stage hold bus from the pipeline controller.
- `flush`  in  1  synchronous bubble insert into ID/EX (exception/redirect).
- `id_valid_i`  in  1  IF/ID holds a real instruction.
- `id_inst_i`  in  32  instruction word.
- `id_pc_i`  in  32  instruction PC.
- `rf_raddr_o`  out  10  {rt, rs} register-file read addresses (combinational).
- `rf_rdata_i`  in  64  {rdata_rt, rdata_rs}.
- `ex_fwd_i`  in  39  {we, is_load, waddr[4:0], wdata[31:0]} from EX.
- `mem_fwd_i`  in  38  {we, waddr[4:0], wdata[31:0]} from MEM.
- `stall_req_o`  out  1  load-use hazard request (combinational).
- `br_taken_o`  out  1  redirect IF this cycle (combinational).
- `br_target_o`  out  32  redirect address.
- `if_flush_o`  out  1  kill the IF/ID instruction. Only driven when `DELAY_SLOT`=0; otherwise 0.
- `ex_valid_o`  out  1  ID/EX slot holds an instruction.
- `ex_aluop_o`  out  4  ALU operation code.
- `ex_op1_o`  out  32  ALU operand 1.
- `ex_op2_o`  out  32  ALU operand 2.
- `ex_we_o`  out  1  register writeback enable.
- `ex_waddr_o`  out  5  writeback register.
- `ex_memop_o`  out  2  00 none, 01 LW, 10 SW.
- `ex_store_data_o`  out  32  forwarded rt value for SW.
- `ex_illegal_o`  out  1  reserved-instruction flag.

## Operation
- **Decoded set.**
  - R-type: ADDU, SUBU, AND, OR, XOR, SLT, SLL, SRL, JR.
  - I/J-type: ADDIU, SLTI, ANDI, ORI, XORI, LUI, LW, SW, BEQ, BNE, J, JAL.
- **Immediates.**
  - Sign-extended: ADDIU, SLTI, LW, SW, branches.
  - Zero-extended: ANDI, ORI, XORI.
  - LUI: op1=0, op2=imm<<16, aluop OR.
- **Shifts.** op1 = zero-extended shamt, op2 = rt value.
- **JAL.** we=1, waddr=31, aluop ADD, op2=0. op1 = pc+8 (`DELAY_SLOT`=1) or pc+4 (`DELAY_SLOT`=0).
- **Operand select, per source.** First match wins:
  1. addr==0 gives 0.
  2. EX we && waddr match && !is_load gives EX wdata.
  3. MEM we && waddr match gives MEM wdata.
  4. Otherwise the register-file data.
- **Load-use.** `stall_req_o`=1 when all of the following hold:
  - `id_valid_i` is 1;
  - EX has we && is_load, with waddr≠0;
  - EX waddr equals a source the instruction actually reads (rs and/or rt, including branch/JR sources).
- **Branch resolution.** Gate: `br_taken_o` is asserted only if `id_valid_i` && !`stall_req_o` && !`stall[STAGE]`.
  - BEQ/BNE: compare the forwarded rs/rt values; target = pc+4+(sext(imm)<<2).
  - J/JAL: target = {(pc+4)[31:28], index, 2'b00}.
  - JR: target = forwarded rs.
  - `if_flush_o` = `br_taken_o` when `DELAY_SLOT`=0.
- **Illegal instruction.** Unknown opcode/funct loads a bubble payload with `ex_valid_o`=1 and `ex_illegal_o`=1.
- **Bubble.** All `ex_*` outputs 0, except `ex_aluop_o`=ALU_NOP.
- **ID/EX update priority, each edge:**
  1. flush gives bubble.
  2. stall[STAGE] && stall[STAGE+1] gives hold.
  3. stall[STAGE] && !stall[STAGE+1] gives bubble.
  4. stall_req_o gives bubble.
  5. !id_valid_i gives bubble.
  6. Otherwise load the decoded values.

## Timing
- Reset: while `rstn`=0, all `ex_*` are 0 immediately (asynchronous), including `ex_aluop_o`=0 (ALU_NOP is encoded 0).
- Combinational outputs during reset still follow their inputs; IF ignores them.
- Decode-to-EX latency: 1 cycle. An instruction presented at edge N appears on `ex_*` after edge N+1.
- `stall_req_o`, `br_taken_o`, `br_target_o`, `if_flush_o` and `rf_raddr_o` are combinational in the same cycle, with no registered state.
- A load-use stall holds for exactly one cycle once the load leaves EX.
- The same instruction then decodes using MEM forwarding.
- If `flush` and a hold are both asserted, `flush` wins.
- Deasserting `rstn` mid-stream needs no recovery cycle.

## Structure
- Shared package `mips_pkg` holds:
  - opcode and funct constants;
  - ALU_* codes: ADD=0x1, SUB=0x2, AND=0x3, OR=0x4, XOR=0x5, SLT=0x6, SLL=0x7, SRL=0x8, NOP=0x0;
  - MEMOP_* codes;
  - the forwarding-bus field offsets.
- Sub-module `id_operand_fwd` implements the operand-select priority. It is instantiated twice (rs, rt).

## Test plan
- **Async reset.** Pulse `rstn` low mid-stream → all `ex_*`=0 without a clock edge.
- **ADDIU decode.** Inputs: 0x2409FFFF, pc 0x100, valid. Next edge → op1=0, op2=0xFFFFFFFF, aluop ADD, we=1, waddr=9, valid=1.
- **Forwarding priority.** ADDU $9,$8,$0 with EX {we=1, waddr=8, data 0x11}, MEM {waddr=8, data 0x22}, RF 0x33 → op1=0x11. With EX we=0 → 0x22. With both off → 0x33. With rs=$0 and all matching → 0.
- **Load-use.** EX LW writing $8, ID ADDU $9,$8,$0 → `stall_req_o`=1 and `ex_valid_o`=0 next cycle. The same case with EX LW to $0 → no stall.
- **Branch.** BEQ at pc 0x1000, offset 4, equal operands → `br_taken_o`=1, target 0x1014. With `DELAY_SLOT`=0 → `if_flush_o`=1. With stall[STAGE]=1 → `br_taken_o`=0.
- **JAL and stall modes.** JAL at pc 0x2000, `DELAY_SLOT`=1 → we=1, waddr=31, op1=0x2008.
  - stall[2]=stall[3]=1 → outputs held.
  - stall[2]=1 only → bubble.
  - flush together with a hold → bubble.
